bus_timer_responder: RTL and testbench

Memory-mapped countdown timer acting as a responder on the CPU's external data bus (address, write data, read data, chip-select, write-enable). Decodes a 16-byte window at `BASE_ADDR`, accepts single-cycle register writes and returns registered read data one `CLK` later, matching the CPU's writeback sampling of external read data. Runs on the system clock and raises a level interrupt on expiry.

---
 rtl/bus_timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 39 +++
 rtl/bus_timer_responder.sv | 127 ++++++++++++
 tb/tb_bus_timer_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer responder:
// register indices, CTRL bit positions and FSM state encoding.
package bus_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_AR = 1;
  localparam int unsigned CTRL_IE = 2;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: while run is high it counts 0..PRESCALE-1 and
// flags a tick on the edge where it holds PRESCALE-1.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/bus_timer_responder.sv
// Countdown timer on the CPU external data bus: 16-byte register window,
// single-cycle writes, registered reads one CLK later, level IRQ on expiry.
module bus_timer_responder
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  input  logic        CS,
  input  logic        WE,
  output logic [31:0] Data_BUS_READ,
  output logic        IRQ
);

  timer_state_e state_q, state_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic [31:0]  load_q, load_d;
  logic [31:0]  count_q, count_d;
  logic         exp_q, exp_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         irq_q, irq_d;

  logic       hit, wr, rd;
  logic [1:0] idx;
  logic       tick, psc_clear, expire;
  logic       unused_addr;

  assign unused_addr = ^ADDR[1:0];

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK  (CLK),
    .Reset(Reset),
    .run  (state_q == ST_RUN),
    .clear(psc_clear),
    .tick (tick)
  );

  always_comb begin
    hit       = CS && (ADDR[31:4] == BASE_ADDR[31:4]);
    wr        = hit && WE;
    rd        = hit && !WE;
    idx       = ADDR[3:2];
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    expire    = 1'b0;
    psc_clear = 1'b0;

    // Hardware counting first; CPU writes below override it on the same edge.
    if (tick && !(wr && idx == REG_COUNT)) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (ctrl_q[CTRL_AR]) begin
          count_d = load_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_STOP;
        end
      end
    end

    if (wr) begin
      case (idx)
        REG_CTRL: begin
          ctrl_d  = Data_BUS_WRITE[2:0];
          state_d = Data_BUS_WRITE[CTRL_EN] ? ST_RUN : ST_STOP;
          if (Data_BUS_WRITE[CTRL_EN] && state_q == ST_STOP) begin
            psc_clear = 1'b1;
          end
        end
        REG_LOAD:  load_d = Data_BUS_WRITE;
        REG_COUNT: begin
          count_d   = Data_BUS_WRITE;
          psc_clear = 1'b1;
        end
        REG_STATUS: ;
      endcase
    end

    // Expiry set beats a simultaneous write-1-to-clear.
    exp_d = (exp_q & ~(wr && idx == REG_STATUS && Data_BUS_WRITE[0])) | expire;
    irq_d = exp_d & ctrl_d[CTRL_IE];

    if (rd) begin
      case (idx)
        REG_CTRL:   rdata_d = {29'd0, ctrl_q};
        REG_LOAD:   rdata_d = load_q;
        REG_COUNT:  rdata_d = count_q;
        REG_STATUS: rdata_d = {31'd0, exp_q};
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_STOP;
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign Data_BUS_READ = rdata_q;
  assign IRQ           = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Scoreboard bench for bus_timer_responder: a behavioural timer model predicts
// read data and IRQ after every edge; a monitor pops and compares.
module tb_bus_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int unsigned P    = 4;

  logic        CLK;
  logic        Reset;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic        CS;
  logic        WE;
  logic [31:0] Data_BUS_READ;
  logic        IRQ;

  bus_timer_responder #(
    .BASE_ADDR(BASE),
    .PRESCALE (P)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .ADDR          (ADDR),
    .Data_BUS_WRITE(Data_BUS_WRITE),
    .CS            (CS),
    .WE            (WE),
    .Data_BUS_READ (Data_BUS_READ),
    .IRQ           (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model: registers plus edges elapsed since the run started.
  logic [31:0] m_load, m_count, m_rd;
  logic [2:0]  m_ctrl;
  bit          m_exp, m_run, m_irq;
  int unsigned m_phase;

  task automatic model_reset();
    m_load = 0; m_count = 0; m_rd = 0; m_ctrl = 0;
    m_exp = 0; m_run = 0; m_irq = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_reg(input int unsigned idx);
    case (idx)
      0: return {29'd0, m_ctrl};
      1: return m_load;
      2: return m_count;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  task automatic model_step(input bit cs, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    bit          hit, tick, wcount, set_exp, nrun;
    int unsigned idx, nphase;
    logic [31:0] nload, ncount;
    logic [2:0]  nctrl;
    hit     = cs && (addr[31:4] == BASE[31:4]);
    idx     = addr[3:2];
    tick    = m_run && ((m_phase % P) == P - 1);
    wcount  = hit && we && idx == 2;
    nload   = m_load; ncount = m_count; nctrl = m_ctrl; nrun = m_run;
    nphase  = m_run ? m_phase + 1 : 0;
    set_exp = 0;
    if (hit && !we) m_rd = model_reg(idx);
    if (tick && !wcount) begin
      if (m_count > 0) ncount = m_count - 1;
      else begin
        set_exp = 1;
        if (m_ctrl[1]) ncount = m_load;
        else begin nctrl[0] = 0; nrun = 0; end
      end
    end
    if (hit && we) begin
      if (idx == 0) begin
        nctrl = wdata[2:0];
        if (wdata[0] && !m_run) nphase = 0;
        nrun = wdata[0];
      end else if (idx == 1) nload = wdata;
      else if (idx == 2) begin ncount = wdata; nphase = 0; end
      else if (wdata[0]) m_exp = 0;
    end
    if (set_exp) m_exp = 1;
    if (!nrun) nphase = 0;
    m_load = nload; m_count = ncount; m_ctrl = nctrl; m_run = nrun; m_phase = nphase;
    m_irq = m_exp && m_ctrl[2];
  endtask

  task automatic bus(input bit cs, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    exp_t e;
    @(negedge CLK);
    CS = cs; WE = we; ADDR = addr; Data_BUS_WRITE = wdata;
    model_step(cs, we, addr, wdata);
    cyc++;
    e.rd = m_rd; e.irq = m_irq; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wr(input int unsigned idx, input logic [31:0] d);
    bus(1, 1, BASE + 32'(idx * 4), d);
  endtask

  task automatic rd(input int unsigned idx);
    bus(1, 0, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), 32'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(0, 1'($urandom), 32'($urandom), 32'($urandom));
  endtask

  // Idle until the model predicts a tick (optionally an expiry) on the next edge.
  task automatic wait_tick(input bit need_expiry, input string what);
    int n;
    n = 0;
    while (!(m_run && (m_phase % P) == P - 1 && (!need_expiry || m_count == 0)) && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: model never reached the event within 200 cycles", what);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (Reset === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (Data_BUS_READ !== e.rd) begin
          errors++;
          $display("FAIL rdata cyc %0d: got %h expected %h", e.cyc, Data_BUS_READ, e.rd);
        end
        checks++;
        if (IRQ !== e.irq) begin
          errors++;
          $display("FAIL irq cyc %0d: got %b expected %b", e.cyc, IRQ, e.irq);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    Reset = 1'b0; CS = 1'b0; WE = 1'b0; ADDR = '0; Data_BUS_WRITE = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Data_BUS_READ !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", Data_BUS_READ);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    @(negedge CLK);
    Reset = 1'b1;

    for (int i = 0; i < 4; i++) rd(i);

    wr(1, 32'd5); rd(1);
    wr(0, 32'hFFFF_FFFF); rd(0);
    wr(0, 32'd0); wr(3, 32'd1); rd(3);

    // One-shot: COUNT=3, EN+IE, expiry 16 edges after the CTRL write.
    wr(2, 32'd3); wr(0, 32'd5);
    idle(20);
    rd(0); rd(2); rd(3);
    wr(3, 32'd1); rd(3);

    // Auto-reload LOAD=2 from COUNT=0.
    wr(1, 32'd2); wr(2, 32'd0); wr(0, 32'd3);
    for (int i = 0; i < 30; i++) rd(2);

    // Clear on the expiry edge loses; clear one cycle later wins.
    wr(0, 32'd7);
    wait_tick(1, "sync_expiry_clear");
    wr(3, 32'd1);
    wr(3, 32'd1);
    rd(3);

    // COUNT write on a tick edge discards the tick.
    wr(2, 32'd9);
    wait_tick(0, "sync_count_write");
    wr(2, 32'd1);
    rd(2); idle(6); rd(2);

    // CTRL EN=1 write on a one-shot expiry edge keeps the timer running.
    wr(0, 32'd0); wr(3, 32'd1); wr(2, 32'd1); wr(0, 32'd5);
    wait_tick(1, "sync_ctrl_write");
    wr(0, 32'd5);
    rd(0); idle(5); rd(2); rd(3);

    // Out-of-window read holds, out-of-window write changes nothing.
    wr(0, 32'd0); wr(1, 32'd5); rd(1);
    bus(1, 0, BASE + 32'h10, 32'd0);
    bus(1, 1, BASE + 32'h18, 32'hDEAD_BEEF);
    bus(1, 1, BASE - 32'h10, 32'h1234_5678);
    for (int i = 0; i < 4; i++) rd(i);

    // Asynchronous reset while counting with IRQ asserted.
    wr(1, 32'd1); wr(2, 32'd0); wr(0, 32'd7);
    idle(10);
    drain();
    @(posedge CLK);
    #3;
    Reset = 1'b0;
    #1;
    checks++;
    if (Data_BUS_READ !== 32'd0) begin
      errors++; $display("FAIL midreset_rdata: got %h expected 0", Data_BUS_READ);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL midreset_irq: got %b expected 0", IRQ);
    end
    model_reset();
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) rd(i);
    idle(8);
    rd(2);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) idle(1);
      else if (r < 60) rd($urandom_range(0, 3));
      else if (r < 66) bus(1, 0, BASE + 32'h10 + 32'($urandom_range(0, 255) * 4), 32'($urandom));
      else if (r < 70) bus(1, 1, BASE + 32'h10 + 32'($urandom_range(0, 255) * 4), 32'($urandom));
      else if (r < 78) wr(2, 32'($urandom_range(0, 6)));
      else if (r < 83) wr(1, 32'($urandom_range(0, 4)));
      else if (r < 92) wr(0, 32'($urandom));
      else wr(3, 32'($urandom));
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
